// File: rtl/lsu_dmem_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_dmem_ctrl_if
// OBI-style data-memory bus bundle between the load/store controller and the
// data memory (or interconnect).
//
// Signals (named from the controller's point of view):
//   data_req_o    controller -> memory  request valid
//   data_we_o     controller -> memory  1 = write
//   data_be_o     controller -> memory  byte enables, one per lane
//   data_addr_o   controller -> memory  word-aligned byte address
//   data_wdata_o  controller -> memory  lane-replicated write data
//   data_gnt_i    memory -> controller  request accepted
//   data_rvalid_i memory -> controller  response valid
//   data_rdata_i  memory -> controller  response data
//   data_err_i    memory -> controller  response error, qualified by rvalid
//
// Handshake: the request phase completes on the cycle where data_req_o and
// data_gnt_i are both high; the request fields are stable while data_req_o is
// high and not yet granted. The response phase is a single cycle with
// data_rvalid_i high; data_rdata_i/data_err_i are only meaningful then.
// -----------------------------------------------------------------------------
interface lsu_dmem_ctrl_if #(
   parameter int ADDR_WIDTH = 32
) ();

   logic                  data_req_o;
   logic                  data_we_o;
   logic [3:0]            data_be_o;
   logic [ADDR_WIDTH-1:0] data_addr_o;
   logic [31:0]           data_wdata_o;
   logic                  data_gnt_i;
   logic                  data_rvalid_i;
   logic [31:0]           data_rdata_i;
   logic                  data_err_i;

   // Controller side
   modport master (
      output data_req_o,
      output data_we_o,
      output data_be_o,
      output data_addr_o,
      output data_wdata_o,
      input  data_gnt_i,
      input  data_rvalid_i,
      input  data_rdata_i,
      input  data_err_i
   );

   // Memory side
   modport slave (
      input  data_req_o,
      input  data_we_o,
      input  data_be_o,
      input  data_addr_o,
      input  data_wdata_o,
      output data_gnt_i,
      output data_rvalid_i,
      output data_rdata_i,
      output data_err_i
   );

endinterface

// File: rtl/lsu_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_dmem_ctrl
// Sequential load/store controller between the core execute stage and an
// OBI-style data memory port. Handles byte/half/word accesses with byte
// enables, store-data lane replication and load sign/zero extension. One
// transaction is outstanding at a time; the core is stalled through o_busy.
//
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   i_req             core access request (held by the core while o_busy)
//   i_we              1 = store, 0 = load
//   i_size            00 byte, 01 half, 10 word, 11 reserved (misaligned)
//   i_unsigned        zero-extend loads
//   i_addr, i_wdata   byte address and LSB-justified store data
//   o_ready / o_busy  controller idle (request accepted) / stall
//   o_done            one-cycle completion pulse per accepted request
//   o_rdata           formatted load data (holds until the next completion)
//   o_err             bus error or timeout, valid with o_done
//   o_timeout         error cause was timeout, valid with o_done
//   o_misaligned      access rejected without a bus cycle, valid with o_done
//   o_dbg_state       current FSM state (0 IDLE, 1 REQ, 2 RESP, 3 DONE)
//   bus               data-memory bus (master side)
//
// Timing with accept at cycle T and a zero-wait memory: data_req_o at T+1,
// grant at T+1, rvalid at T+2, o_done at T+3. Misaligned: o_done at T+1.
// -----------------------------------------------------------------------------
module lsu_dmem_ctrl #(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TIMEOUT_EN     = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  i_req,
   input  logic                  i_we,
   input  logic [1:0]            i_size,
   input  logic                  i_unsigned,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [31:0]           i_wdata,
   output logic                  o_ready,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [31:0]           o_rdata,
   output logic                  o_err,
   output logic                  o_timeout,
   output logic                  o_misaligned,
   output logic [1:0]            o_dbg_state,
   lsu_dmem_ctrl_if.master       bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // One extra bit so the counter can step past the terminal count when a
   // grant lands exactly on it (the response phase then times out next cycle).
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   state_e                state_q,  state_d;
   logic [CNT_W-1:0]      cnt_q,    cnt_d;
   logic [1:0]            size_q,   size_d;
   logic                  uns_q,    uns_d;
   logic [1:0]            off_q,    off_d;

   logic                  req_q,    req_d;
   logic                  we_q,     we_d;
   logic [3:0]            be_q,     be_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [31:0]           wdata_q,  wdata_d;

   logic                  done_q,   done_d;
   logic [31:0]           rdata_q,  rdata_d;
   logic                  err_q,    err_d;
   logic                  tmo_q,    tmo_d;
   logic                  mis_q,    mis_d;

   // ---------------------------------------------------------------------------
   // Request decode (from the core inputs, used on accept)
   // ---------------------------------------------------------------------------
   logic [1:0]  acc_off;
   logic        acc_mis;
   logic [3:0]  acc_be;
   logic [31:0] acc_wdata;

   always_comb begin
      acc_off   = i_addr[1:0];
      acc_mis   = 1'b0;
      acc_be    = 4'b1111;
      acc_wdata = i_wdata;
      unique case (i_size)
         2'b00: begin
            acc_be    = 4'b0001 << acc_off;
            acc_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            acc_mis   = acc_off[0];
            acc_be    = 4'b0011 << acc_off;
            acc_wdata = {2{i_wdata[15:0]}};
         end
         2'b10: begin
            acc_mis   = (acc_off != 2'b00);
         end
         default: begin
            acc_mis   = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Load formatting (from the captured access attributes and bus data)
   // ---------------------------------------------------------------------------
   logic [31:0] ld_shift;
   logic [31:0] ld_data;

   always_comb begin
      ld_shift = bus.data_rdata_i >> {off_q, 3'b000};
      ld_data  = ld_shift;
      unique case (size_q)
         2'b00:   ld_data = uns_q ? {24'b0, ld_shift[7:0]}
                                  : {{24{ld_shift[7]}}, ld_shift[7:0]};
         2'b01:   ld_data = uns_q ? {16'b0, ld_shift[15:0]}
                                  : {{16{ld_shift[15]}}, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   // Terminal count reached; the caller checks gnt/rvalid first so a normal
   // handshake in the same cycle takes priority over the abort.
   logic timeout_hit;
   assign timeout_hit = (TIMEOUT_EN != 0) && (cnt_q >= CNT_LAST);

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      size_d  = size_q;
      uns_d   = uns_q;
      off_d   = off_q;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      // Completion flags are single-cycle pulses
      done_d  = 1'b0;
      err_d   = 1'b0;
      tmo_d   = 1'b0;
      mis_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (i_req) begin
               size_d = i_size;
               uns_d  = i_unsigned;
               off_d  = acc_off;
               if (acc_mis) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  mis_d   = 1'b1;
                  rdata_d = 32'b0;
               end else begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = i_we;
                  be_d    = acc_be;
                  addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                  wdata_d = acc_wdata;
                  cnt_d   = '0;
               end
            end
         end

         S_REQ: begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            // rvalid is deliberately not looked at here
            if (bus.data_gnt_i) begin
               state_d = S_RESP;
               req_d   = 1'b0;
            end else if (timeout_hit) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               done_d  = 1'b1;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               rdata_d = 32'b0;
            end
         end

         S_RESP: begin
            if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (bus.data_rvalid_i) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = bus.data_err_i;
               // Stores and errored responses report zero data
               rdata_d = (bus.data_err_i || we_q) ? 32'b0 : ld_data;
            end else if (timeout_hit) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               rdata_d = 32'b0;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         off_q   <= 2'b00;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'b0;
         addr_q  <= '0;
         wdata_q <= 32'b0;
         done_q  <= 1'b0;
         rdata_q <= 32'b0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         off_q   <= off_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
         mis_q   <= mis_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign o_ready          = (state_q == S_IDLE);
   assign o_busy           = ~o_ready;
   assign o_done           = done_q;
   assign o_rdata          = rdata_q;
   assign o_err            = err_q;
   assign o_timeout        = tmo_q;
   assign o_misaligned     = mis_q;
   assign o_dbg_state      = state_q;

   assign bus.data_req_o   = req_q;
   assign bus.data_we_o    = we_q;
   assign bus.data_be_o    = be_q;
   assign bus.data_addr_o  = addr_q;
   assign bus.data_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Testbench for lsu_dmem_ctrl. The bench plays both the core and the data
// memory. Inputs are driven and outputs sampled on the falling clock edge.
module tb_lsu_dmem_ctrl;
  localparam int AW = 32;
  localparam int TC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          i_req, i_we, i_unsigned;
  logic [1:0]    i_size;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_wdata;
  logic          o_ready, o_busy, o_done, o_err, o_timeout, o_misaligned;
  logic [31:0]   o_rdata;
  logic [1:0]    o_dbg_state;

  lsu_dmem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  lsu_dmem_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TC), .TIMEOUT_EN(1)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_size       (i_size),
    .i_unsigned   (i_unsigned),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_ready      (o_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_err        (o_err),
    .o_timeout    (o_timeout),
    .o_misaligned (o_misaligned),
    .o_dbg_state  (o_dbg_state),
    .bus          (bus.master)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'd3) || ((addr % nbytes(sz)) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] be;
    int off = int'(addr % 4);
    be = 4'b0;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(sz));
    return be;
  endfunction

  // Each lane i carries store byte (i mod access size)
  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    r = 32'b0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                             input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int n   = nbytes(sz);
    int off = int'(addr % 4);
    v = 32'b0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off + i) +: 8];
    if (!uns && n < 4 && v[8*n-1])
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    bus.data_rdata_i  = 32'b0;
    bus.data_err_i    = 1'b0;
  endtask

  // One full access. gdel = cycles before grant, rdel = cycles in RESP before
  // rvalid; junk = stray rvalid pulses while waiting for the grant.
  task automatic do_access(input string tag, input bit we, input logic [1:0] sz, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int gdel, input int rdel,
                           input logic [31:0] rd, input bit err, input bit junk);
    bit          mis = model_mis(sz, addr);
    logic [31:0] exp_rd;
    check({tag, ":ready"}, 32'(o_ready), 32'd1);
    i_req = 1'b1; i_we = we; i_size = sz; i_unsigned = uns; i_addr = addr; i_wdata = wd;
    @(negedge clk);
    i_req = 1'b0; i_addr = $urandom; i_wdata = $urandom;
    if (mis) begin
      check({tag, ":mis_done"}, 32'(o_done), 32'd1);
      check({tag, ":mis_flag"}, 32'(o_misaligned), 32'd1);
      check({tag, ":mis_err"},  32'(o_err), 32'd0);
      check({tag, ":mis_req"},  32'(bus.data_req_o), 32'd0);
      @(negedge clk);
      check({tag, ":mis_back"}, 32'(o_ready), 32'd1);
      return;
    end
    exp_rd = err ? 32'b0 : (we ? 32'b0 : model_load(sz, uns, addr, rd));
    exp_q.push_back(exp_rd);
    for (int c = 0; c <= gdel; c++) begin
      check({tag, ":req"},   32'(bus.data_req_o), 32'd1);
      check({tag, ":addr"},  bus.data_addr_o, addr & 32'hFFFF_FFFC);
      check({tag, ":be"},    32'(bus.data_be_o), 32'(model_be(sz, addr)));
      check({tag, ":wdata"}, bus.data_wdata_o, model_wdata(sz, wd));
      check({tag, ":we"},    32'(bus.data_we_o), 32'(we));
      check({tag, ":busy"},  32'(o_busy), 32'd1);
      bus.data_gnt_i    = (c == gdel);
      bus.data_rvalid_i = junk && ($urandom_range(0, 1) == 1);
      bus.data_err_i    = 1'b1;
      bus.data_rdata_i  = $urandom;
      @(negedge clk);
    end
    idle_bus();
    for (int c = 0; c <= rdel; c++) begin
      check({tag, ":req_low"}, 32'(bus.data_req_o), 32'd0);
      check({tag, ":no_done"}, 32'(o_done), 32'd0);
      bus.data_rvalid_i = (c == rdel);
      bus.data_rdata_i  = (c == rdel) ? rd : $urandom;
      bus.data_err_i    = (c == rdel) ? err : 1'b0;
      @(negedge clk);
    end
    idle_bus();
    check({tag, ":done"},  32'(o_done), 32'd1);
    check({tag, ":rdata"}, o_rdata, exp_q.pop_front());
    check({tag, ":err"},   32'(o_err), 32'(err));
    check({tag, ":tmo"},   32'(o_timeout), 32'd0);
    check({tag, ":misf"},  32'(o_misaligned), 32'd0);
    @(negedge clk);
    check({tag, ":done_clr"}, 32'(o_done), 32'd0);
    check({tag, ":hold"},     o_rdata, exp_rd);
    check({tag, ":idle"},     32'(o_ready), 32'd1);
  endtask

  // Load that never completes: expect abort after TC cycles in REQ+RESP.
  task automatic do_timeout(input string tag, input bit give_gnt);
    int n;
    check({tag, ":ready"}, 32'(o_ready), 32'd1);
    i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_unsigned = 1'b0; i_addr = 32'h0000_0400;
    @(negedge clk);
    i_req = 1'b0;
    n = 1;
    while (!o_done && n < 40) begin
      bus.data_gnt_i = give_gnt && (n == 1);
      if (!give_gnt) check({tag, ":req_hold"}, 32'(bus.data_req_o), 32'd1);
      @(negedge clk);
      n++;
    end
    idle_bus();
    check({tag, ":latency"}, 32'(n), 32'(TC + 1));
    check({tag, ":err"},     32'(o_err), 32'd1);
    check({tag, ":tmo"},     32'(o_timeout), 32'd1);
    check({tag, ":rdata"},   o_rdata, 32'd0);
    check({tag, ":req_drop"}, 32'(bus.data_req_o), 32'd0);
    @(negedge clk);
    // Late response after the abort must be ignored
    bus.data_rvalid_i = 1'b1;
    bus.data_rdata_i  = 32'h1234_5678;
    @(negedge clk);
    idle_bus();
    for (int c = 0; c < 3; c++) begin
      check({tag, ":stray"}, 32'(o_done), 32'd0);
      check({tag, ":stray_rdy"}, 32'(o_ready), 32'd1);
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'd0; i_unsigned = 1'b0;
    i_addr = '0; i_wdata = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst:ready", 32'(o_ready), 32'd1);
    check("rst:busy",  32'(o_busy), 32'd0);
    check("rst:req",   32'(bus.data_req_o), 32'd0);
    check("rst:done",  32'(o_done), 32'd0);
    check("rst:rdata", o_rdata, 32'd0);
    check("rst:be",    32'(bus.data_be_o), 32'd0);
    check("rst:addr",  bus.data_addr_o, 32'd0);

    // Directed cases
    do_access("lw",   0, 2'd2, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
    do_access("lb",   0, 2'd0, 0, 32'h103, 32'h0, 0, 0, 32'h80112233, 0, 0);
    do_access("lbu",  0, 2'd0, 1, 32'h103, 32'h0, 0, 0, 32'h80112233, 0, 0);
    do_access("lh",   0, 2'd1, 0, 32'h102, 32'h0, 0, 0, 32'h80112233, 0, 0);
    do_access("sh",   1, 2'd1, 0, 32'h202, 32'h0000ABCD, 3, 0, 32'h0, 0, 0);
    do_access("lw_m", 0, 2'd2, 0, 32'h101, 32'h0, 0, 0, 32'h0, 0, 0);
    do_access("sh_m", 1, 2'd1, 0, 32'h303, 32'h0, 0, 0, 32'h0, 0, 0);
    do_access("sz3",  0, 2'd3, 0, 32'h300, 32'h0, 0, 0, 32'h0, 0, 0);
    do_access("lerr", 0, 2'd2, 0, 32'h104, 32'h0, 1, 1, 32'hCAFEF00D, 1, 0);
    // Completion exactly on the terminal count
    do_access("edge", 0, 2'd2, 0, 32'h108, 32'h0, 3, 3, 32'h0BADC0DE, 0, 1);
    do_timeout("tmo_g", 1);
    do_timeout("tmo_n", 0);

    // Reset while waiting for the response
    i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_addr = 32'h500;
    @(negedge clk);
    i_req = 1'b0;
    bus.data_gnt_i = 1'b1;
    @(negedge clk);
    idle_bus();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst:ready", 32'(o_ready), 32'd1);
    check("mrst:req",   32'(bus.data_req_o), 32'd0);
    check("mrst:done",  32'(o_done), 32'd0);
    check("mrst:rdata", o_rdata, 32'd0);
    check("mrst:be",    32'(bus.data_be_o), 32'd0);
    check("mrst:addr",  bus.data_addr_o, 32'd0);
    check("mrst:we",    32'(bus.data_we_o), 32'd0);
    do_access("post", 0, 2'd2, 0, 32'h600, 32'h0, 0, 0, 32'h13579BDF, 0, 0);

    // Randomized accesses
    for (int k = 0; k < 80; k++) begin
      logic [1:0]  sz   = 2'($urandom_range(0, 3));
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(nbytes(sz)) - 32'd1);
      do_access("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
                $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Overall time limit
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
